// File: rtl/sha1_pad_if.sv
// Word-stream handshake bundle for the SHA-1 padder: message words in, padded block words out.
interface sha1_pad_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic [2:0]  in_bytes;
  logic        in_last;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic        out_first;
  logic        out_last;

  modport master (
    output in_valid, in_data, in_bytes, in_last, out_ready,
    input  in_ready, out_valid, out_data, out_first, out_last
  );

  modport slave (
    input  in_valid, in_data, in_bytes, in_last, out_ready,
    output in_ready, out_valid, out_data, out_first, out_last
  );
endinterface

// File: rtl/sha1_pad.sv
// SHA-1 message padder: 0x80 marker, zero fill, 64-bit bit length; one-word output register, latency 1.
// Input is accepted only when the output register is free or draining that cycle; out_valid/out_data hold under backpressure.
module sha1_pad (
  input  logic       wb_clk_i,
  input  logic       reset_n,
  input  logic       start,
  sha1_pad_if.slave  bus,
  output logic       busy,
  output logic       done
);
  typedef enum logic [2:0] {IDLE, DATA, PAD, ZERO, LEN_HI, LEN_LO} state_t;

  state_t      state;
  logic [63:0] bit_len;
  logic [3:0]  word_idx;
  logic        out_vld_r;
  logic [31:0] out_dat_r;
  logic        out_first_r;
  logic        out_last_r;

  logic [2:0]  nb;
  logic [31:0] in_word;
  logic        can_load;
  logic        in_rdy;
  logic        in_fire;
  logic        out_fire;
  logic [3:0]  load_idx;
  logic        len_next;
  logic        ld_en;
  logic [31:0] ld_dat;
  logic        ld_last;

  always_comb begin
    nb = (bus.in_bytes > 3'd4) ? 3'd4 : bus.in_bytes;
    in_word = '0;
    // Keep valid bytes; the terminating marker goes right after them on a short last word.
    for (int b = 0; b < 4; b++) begin
      if (3'(b) < nb)
        in_word[31-8*b -: 8] = bus.in_data[31-8*b -: 8];
      else if (bus.in_last && 3'(b) == nb)
        in_word[31-8*b -: 8] = 8'h80;
    end

    can_load = !out_vld_r || bus.out_ready;
    in_rdy   = (state == DATA) && can_load && !start;
    in_fire  = bus.in_valid && in_rdy;
    out_fire = out_vld_r && bus.out_ready;
    // Index of the word that a load this cycle would occupy.
    load_idx = word_idx + {3'b000, out_vld_r};
    len_next = (load_idx + 4'd1) == 4'd14;

    ld_en   = 1'b0;
    ld_dat  = '0;
    ld_last = 1'b0;
    case (state)
      DATA: begin
        ld_en  = in_fire && (nb != 3'd0 || bus.in_last);
        ld_dat = in_word;
      end
      PAD: begin
        ld_en  = can_load;
        ld_dat = 32'h8000_0000;
      end
      ZERO:   ld_en = can_load;
      LEN_HI: begin
        ld_en  = can_load;
        ld_dat = bit_len[63:32];
      end
      LEN_LO: begin
        ld_en   = can_load && !(out_vld_r && out_last_r);
        ld_dat  = bit_len[31:0];
        ld_last = 1'b1;
      end
      default: ld_en = 1'b0;
    endcase
  end

  always_ff @(posedge wb_clk_i or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      bit_len     <= '0;
      word_idx    <= '0;
      out_vld_r   <= 1'b0;
      out_dat_r   <= '0;
      out_first_r <= 1'b0;
      out_last_r  <= 1'b0;
      done        <= 1'b0;
    end else begin
      done <= 1'b0;
      if (start) begin
        state       <= DATA;
        bit_len     <= '0;
        word_idx    <= '0;
        out_vld_r   <= 1'b0;
        out_first_r <= 1'b0;
        out_last_r  <= 1'b0;
      end else begin
        if (out_fire) begin
          out_vld_r <= 1'b0;
          word_idx  <= word_idx + 4'd1;
        end
        if (ld_en) begin
          out_vld_r   <= 1'b1;
          out_dat_r   <= ld_dat;
          out_first_r <= (load_idx == 4'd0);
          out_last_r  <= ld_last;
        end
        case (state)
          IDLE: ;
          DATA: begin
            if (ld_en) bit_len <= bit_len + {58'd0, nb, 3'b000};
            if (ld_en && bus.in_last)
              state <= (nb == 3'd4) ? PAD : (len_next ? LEN_HI : ZERO);
          end
          PAD, ZERO: if (ld_en) state <= len_next ? LEN_HI : ZERO;
          LEN_HI:    if (ld_en) state <= LEN_LO;
          LEN_LO: begin
            if (out_vld_r && out_last_r && bus.out_ready) begin
              done  <= 1'b1;
              state <= IDLE;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  assign bus.in_ready  = in_rdy;
  assign bus.out_valid = out_vld_r;
  assign bus.out_data  = out_dat_r;
  assign bus.out_first = out_first_r;
  assign bus.out_last  = out_last_r;
  assign busy          = (state != IDLE);
endmodule

// File: tb/tb_sha1_pad.sv
// Bench for sha1_pad: random messages checked against textbook SHA-1 padding of the byte stream.
module tb_sha1_pad;
  logic wb_clk_i = 1'b0;
  logic reset_n;
  logic start;
  logic busy;
  logic done;

  sha1_pad_if bus();

  sha1_pad dut (
    .wb_clk_i (wb_clk_i),
    .reset_n  (reset_n),
    .start    (start),
    .bus      (bus),
    .busy     (busy),
    .done     (done)
  );

  always #5 wb_clk_i = ~wb_clk_i;

  int tests = 0;
  int fails = 0;

  logic [7:0]  msg_q[$];
  logic [31:0] st_dat[$];
  logic [2:0]  st_bytes[$];
  logic        st_last[$];
  logic [33:0] exp_q[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] ref_v);
    tests++;
    assert (obs === ref_v) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, ref_v);
    end
  endtask

  task automatic rand_msg(input int n);
    msg_q.delete();
    for (int i = 0; i < n; i++) msg_q.push_back(8'($urandom));
  endtask

  // Stimulus words (with occasional discardable empty words) plus the expected padded stream.
  task automatic build_stim_and_model();
    int n;
    int nw;
    int nb;
    int nwords;
    logic [31:0] d;
    logic [63:0] bitlen;
    logic [7:0]  padded[$];
    n  = msg_q.size();
    nw = (n == 0) ? 1 : (n + 3) / 4;
    st_dat.delete(); st_bytes.delete(); st_last.delete(); exp_q.delete();
    for (int w = 0; w < nw; w++) begin
      nb = (w == nw - 1) ? n - 4 * w : 4;
      if ($urandom_range(0, 5) == 0) begin
        st_dat.push_back($urandom);
        st_bytes.push_back(3'd0);
        st_last.push_back(1'b0);
      end
      d = $urandom;
      for (int b = 0; b < nb; b++) d[31-8*b -: 8] = msg_q[4*w+b];
      st_dat.push_back(d);
      st_bytes.push_back((nb == 4 && $urandom_range(0, 2) == 0) ? 3'($urandom_range(5, 7)) : 3'(nb));
      st_last.push_back(w == nw - 1);
    end
    padded = msg_q;
    padded.push_back(8'h80);
    while (padded.size() % 64 != 56) padded.push_back(8'h00);
    bitlen = 64'(n) * 64'd8;
    for (int k = 7; k >= 0; k--) padded.push_back(bitlen[8*k +: 8]);
    nwords = padded.size() / 4;
    for (int i = 0; i < nwords; i++)
      exp_q.push_back({(i % 16 == 0), (i == nwords - 1),
                       padded[4*i], padded[4*i+1], padded[4*i+2], padded[4*i+3]});
  endtask

  task automatic pulse_start();
    @(posedge wb_clk_i); #1 start = 1'b1;
    @(posedge wb_clk_i); #1 start = 1'b0;
  endtask

  task automatic drive_word(input logic [31:0] d, input logic [2:0] nb, input logic last);
    logic acc;
    int   cnt;
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    bus.in_bytes = nb;
    bus.in_last  = last;
    acc = 1'b0;
    cnt = 0;
    while (!acc && cnt < 2000) begin
      @(negedge wb_clk_i);
      acc = bus.in_ready;
      @(posedge wb_clk_i); #1;
      cnt++;
    end
    if (!acc) chk("in_accept_timeout", 64'(acc), 64'd1);
    bus.in_valid = 1'b0;
  endtask

  task automatic drive_all();
    for (int i = 0; i < st_dat.size(); i++) begin
      repeat ($urandom_range(0, 2)) begin @(posedge wb_clk_i); #1; end
      drive_word(st_dat[i], st_bytes[i], st_last[i]);
    end
  endtask

  task automatic monitor_all();
    int          budget;
    logic        held;
    logic [31:0] hold_dat;
    logic [33:0] e;
    budget = 0;
    held   = 1'b0;
    hold_dat = '0;
    while (exp_q.size() > 0 && budget < 4000) begin
      bus.out_ready = ($urandom_range(0, 3) != 0);
      @(negedge wb_clk_i);
      if (held) begin
        chk("hold_valid", 64'(bus.out_valid), 64'd1);
        chk("hold_data", 64'(bus.out_data), 64'(hold_dat));
      end
      held = 1'b0;
      if (bus.out_valid && bus.out_ready) begin
        e = exp_q.pop_front();
        chk("out_data", 64'(bus.out_data), 64'(e[31:0]));
        chk("out_first", 64'(bus.out_first), 64'(e[33]));
        chk("out_last", 64'(bus.out_last), 64'(e[32]));
      end else if (bus.out_valid) begin
        held = 1'b1;
        hold_dat = bus.out_data;
      end
      @(posedge wb_clk_i); #1;
      budget++;
    end
    chk("out_words_left", 64'(exp_q.size()), 64'd0);
    @(negedge wb_clk_i);
    chk("done_pulse", 64'(done), 64'd1);
    chk("busy_idle", 64'(busy), 64'd0);
    @(negedge wb_clk_i);
    chk("done_single", 64'(done), 64'd0);
  endtask

  task automatic run_msg();
    build_stim_and_model();
    pulse_start();
    fork
      drive_all();
      monitor_all();
    join
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk(tag, 64'({bus.in_ready, bus.out_valid, bus.out_first, bus.out_last, busy, done}), 64'd0);
    chk("rst_out_data", 64'(bus.out_data), 64'd0);
  endtask

  initial begin
    logic [31:0] w0;
    logic [31:0] w1;
    int          seen;

    reset_n      = 1'b0;
    start        = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    bus.in_bytes = '0;
    bus.in_last  = 1'b0;
    bus.out_ready = 1'b0;

    // Reset state, then input ignored while idle.
    repeat (3) @(posedge wb_clk_i);
    #1 chk_reset_outputs("reset_ctrl");
    @(negedge wb_clk_i) reset_n = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_data  = $urandom;
    bus.in_bytes = 3'd4;
    @(negedge wb_clk_i);
    chk("idle_in_ready", 64'(bus.in_ready), 64'd0);
    @(negedge wb_clk_i);
    chk("idle_out_valid", 64'(bus.out_valid), 64'd0);
    bus.in_valid = 1'b0;

    // Empty message and "abc".
    msg_q.delete();
    run_msg();
    msg_q = '{8'h61, 8'h62, 8'h63};
    run_msg();

    // Padding boundaries: marker at index 13, 14, 15, block-aligned, long messages.
    rand_msg(55);  run_msg();
    rand_msg(56);  run_msg();
    rand_msg(60);  run_msg();
    rand_msg(64);  run_msg();
    rand_msg(119); run_msg();

    // Backpressure mid-block, then abort by start and send "abc".
    pulse_start();
    bus.out_ready = 1'b1;
    w0 = $urandom;
    w1 = $urandom;
    bus.in_valid = 1'b1;
    bus.in_data  = w0;
    bus.in_bytes = 3'd4;
    bus.in_last  = 1'b0;
    @(negedge wb_clk_i);
    chk("bp_in_ready_empty", 64'(bus.in_ready), 64'd1);
    @(posedge wb_clk_i); #1;
    bus.out_ready = 1'b0;
    bus.in_data   = w1;
    repeat (3) begin
      @(negedge wb_clk_i);
      chk("bp_valid", 64'(bus.out_valid), 64'd1);
      chk("bp_data", 64'(bus.out_data), 64'(w0));
      chk("bp_first", 64'(bus.out_first), 64'd1);
      chk("bp_in_ready", 64'(bus.in_ready), 64'd0);
      @(posedge wb_clk_i); #1;
    end
    bus.out_ready = 1'b1;
    @(negedge wb_clk_i);
    chk("bp_in_ready_release", 64'(bus.in_ready), 64'd1);
    @(posedge wb_clk_i); #1;
    bus.in_valid = 1'b0;
    @(negedge wb_clk_i);
    chk("bp_next_data", 64'(bus.out_data), 64'(w1));
    chk("bp_next_first", 64'(bus.out_first), 64'd0);
    for (int i = 0; i < 3; i++) drive_word($urandom, 3'd4, 1'b0);
    msg_q = '{8'h61, 8'h62, 8'h63};
    run_msg();

    // Random lengths.
    for (int i = 0; i < 6; i++) begin
      rand_msg($urandom_range(1, 140));
      run_msg();
    end

    // Reset mid-block discards the message; nothing comes out until a new start.
    rand_msg(40);
    build_stim_and_model();
    pulse_start();
    bus.out_ready = 1'b1;
    for (int i = 0; i < 4; i++) drive_word(st_dat[i], st_bytes[i], st_last[i]);
    reset_n = 1'b0;
    #1 chk_reset_outputs("midrst_ctrl");
    @(posedge wb_clk_i);
    @(negedge wb_clk_i) reset_n = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_data  = $urandom;
    bus.in_bytes = 3'd4;
    seen = 0;
    repeat (20) begin
      @(negedge wb_clk_i);
      if (bus.out_valid || bus.in_ready || busy) seen++;
    end
    chk("post_reset_quiet", 64'(seen), 64'd0);
    bus.in_valid = 1'b0;

    rand_msg(20);
    run_msg();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/sha1_pad.md
SHA1_PAD -- requirements
Module: sha1_pad

Interface
REQ-001 SHALL have parameter: none; the block is fixed at 32-bit words, 512-bit blocks, 64-bit big-endian bit length.
REQ-002 SHALL have ports: wb_clk_i  in  1  sole clock, all state on rising edge.
REQ-003 SHALL have ports: reset_n  in  1  asynchronous, active-low reset.
REQ-004 SHALL have ports: start  in  1  single-cycle pulse that begins a new message and clears all counters.
REQ-005 SHALL have ports: in_valid  in  1; in_ready  out  1  input word handshake.
REQ-006 SHALL have ports: in_data  in  32  message bytes, big-endian, first byte in [31:24].
REQ-007 SHALL have ports: in_bytes  in  3  valid bytes in in_data (1-4; 0 legal only with in_last).
REQ-008 SHALL have ports: in_last  in  1  word is final word of message.
REQ-009 SHALL have ports: out_valid  out  1; out_ready  in  1  output word handshake.
REQ-010 SHALL have ports: out_data  out  32; out_first  out  1  (word index 0 of a block); out_last  out  1  (word 15 of final block).
REQ-011 SHALL have ports: busy  out  1  (state != IDLE); done  out  1  (one-cycle pulse after final word accepted).

Function
REQ-012 SHALL implement states IDLE, DATA, PAD, ZERO, LEN_HI, LEN_LO.
REQ-013 SHALL move IDLE->DATA on start; start in any non-IDLE state SHALL abort: drop out_valid, clear counters, enter DATA.
REQ-014 SHALL assert in_ready only in DATA and when output register is empty or out_ready=1 that cycle.
REQ-015 SHALL present an accepted input word on out_data the next cycle (latency 1); out_valid/out_data SHALL hold stable until out_ready=1.
REQ-016 SHALL force bytes beyond in_bytes to 0x00 on output.
REQ-017 SHALL add 8*in_bytes to a 64-bit bit-length counter per accepted word, wrapping modulo 2^64.
REQ-018 SHALL maintain a 4-bit word index incremented per output word accepted, wrapping 15->0; out_first SHALL equal (index==0).
REQ-019 On in_last with in_bytes<4: SHALL insert 0x80 at byte position in_bytes of the same output word, then go to ZERO.
REQ-020 On in_last with in_bytes==4: SHALL go to PAD, emitting 0x80000000 as the next word, then ZERO.
REQ-021 ZERO SHALL emit 0x00000000 words until the next word index is 14, then go to LEN_HI; if the 0x80 word lands at index 14 or 15, ZERO SHALL fill through index 15 and the whole next block through index 13.
REQ-022 LEN_HI SHALL emit length[63:32]; LEN_LO SHALL emit length[31:0] with out_last=1.
REQ-023 On acceptance of the LEN_LO word: SHALL pulse done for one cycle and return to IDLE.
REQ-024 An accepted word with in_bytes=0 and in_last=0 SHALL be discarded: no output, no count.
REQ-025 in_bytes 5-7 SHALL be treated as 4.
REQ-026 in_valid while not in DATA SHALL be ignored (in_ready=0).

Reset
REQ-027 While reset_n=0: SHALL hold in_ready=0, out_valid=0, out_data=0, out_first=0, out_last=0, busy=0, done=0; state=IDLE, length=0, word index=0.
REQ-028 Reset assertion mid-message SHALL discard the partial message; no output word appears after deassertion until a new start.

Verification
REQ-029 Empty message: start; in_bytes=0, in_last=1 -> 16 words: 0x80000000, 13x 0x00000000, 0x00000000, 0x00000000; out_last on word 15; done pulse.
REQ-030 "abc": in_data=0x61626300, in_bytes=3, in_last -> word0 0x61626380, words1-14 0, word15 0x00000018.
REQ-031 55 bytes (13 full words + last 3 bytes) -> word13 = data|0x80 in byte 3, word14 0, word15 0x000001B8; one block.
REQ-032 56 bytes (14 full words, last full) -> word14 0x80000000, word15 0, second block words0-13 0, word14 0, word15 0x000001C0; out_first twice; 32 words.
REQ-033 Backpressure: out_ready=0 for 3 cycles mid-block -> out_data stable, in_ready=0, no word lost or duplicated.
REQ-034 Abort/reset: start after 5 words, then "abc" -> single block with length 0x18; reset_n low mid-block -> all outputs 0, no further output.
